// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants, state encoding and the enabled-channel search used by
// the scan sequencer in front of the 4:1 select mux.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } next_ch_t;

  // Lowest enabled index strictly above cur; the descending loop lets the
  // lowest candidate win.
  function automatic next_ch_t next_ch(input logic [NUM_CH-1:0] mask,
                                       input logic [SEL_W-1:0]  cur);
    next_ch_t res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        res.found = 1'b1;
        res.idx   = SEL_W'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/output and snapshot result bundle between the
// scan sequencer (slave) and its user plus the downstream mux (master).
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] en;
  logic              q;
  logic [SEL_W-1:0]  select;
  logic              busy;
  logic              valid;
  logic [NUM_CH-1:0] data;

  modport slave  (input  start, en, q, output select, busy, valid, data);
  modport master (output start, en, q, input  select, busy, valid, data);

endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through the enabled channels, holds each for DWELL
// cycles, samples q and publishes a 4-bit snapshot with a one-cycle strobe.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] snap_q, snap_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  next_ch_t          nxt;
  logic [NUM_CH-1:0] cap;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    snap_d  = snap_q;
    data_d  = data_q;
    valid_d = 1'b0;
    nxt     = next_ch(en_q, sel_q);
    cap     = snap_q;
    cap[sel_q] = bus.q;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          snap_d = cap;
          cnt_d  = '0;
          if (nxt.found) begin
            sel_d = nxt.idx;
          end else begin
            state_d = ST_DONE;
            data_d  = cap;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new scan; DONE->SETTLE gives back-to-back runs.
        if (bus.start) begin
          en_d   = bus.en;
          snap_d = '0;
          cnt_d  = '0;
          if (bus.en != '0) begin
            sel_d   = first_ch(bus.en);
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
            data_d  = '0;
            valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      snap_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.select = sel_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.data   = data_q;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing stage directly upstream of the team's 4:1 select mux (`select[1:0]`, `d[3:0]` → `q`). On a `start` pulse it steps `select` through the enabled channels, holds each for a programmable settle time, samples the mux output `q` and assembles a 4-bit snapshot. Each snapshot is presented on `data` with a one-cycle `valid` strobe. The mux itself is unchanged: this block drives its `select` and consumes its `q`.

## Interface
- `DWELL`, default 2: cycles `select` is held per channel before `q` is sampled; legal range 1–16.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request one scan; accepted only when `busy`=0.
- `en`  in  4  channel enable mask; sampled together with an accepted `start`.
- `q`  in  1  mux output, driven by the downstream mux.
- `select`  out  2  mux channel select, driven to the downstream mux.
- `busy`  out  1  scan in progress.
- `valid`  out  1  one-cycle strobe: `data` holds a completed snapshot.
- `data`  out  4  snapshot; bit i = `q` sampled with `select`=i, or 0 if channel i is disabled.

## Operation
- States:
  - IDLE: after reset.
  - SETTLE: holding a channel.
  - DONE: one cycle, `valid`=1.
- Reset (`rst_n`=0 at an edge) forces IDLE, `select`=0, `busy`=0, `valid`=0, `data`=0, dwell counter 0, latched mask 0. This applies mid-scan as well; the partial snapshot is discarded.
- IDLE or DONE with `start`=1:
  - `en` is latched into `en_r` and the snapshot register is cleared.
  - `en`≠0: `select` ← lowest enabled index, counter ← 0, go to SETTLE.
  - `en`=0: go to DONE; `data`=0.
- SETTLE:
  - The counter increments each edge.
  - On the edge where the counter is `DWELL`−1, `q` is written to `data_r[select]`.
  - If a higher enabled channel remains, `select` ← next enabled index, counter ← 0, stay in SETTLE. Otherwise go to DONE.
- DONE: `valid`=1 for one cycle, then IDLE, or SETTLE again if `start`=1 in that cycle (back-to-back scans).
- `start` while `busy`=1 is ignored; no queuing.
- `data` is updated only on completion. It holds its value through IDLE and through the next scan until that scan completes.
- `select` holds its last value in IDLE and DONE.
- Channels are visited in ascending index order. Disabled channels are skipped with zero cycles spent.

## Timing
- `busy` is 1 exactly while in SETTLE.
- For k enabled channels, `valid` rises on the k·`DWELL`-th edge after the edge that accepted `start`. For k=0 it rises on the next edge.
- `q` is sampled `DWELL` edges after `select` changes. The combinational mux path `select`→`q` must settle within one cycle when `DWELL`=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter width is `$clog2(DWELL)`, with a minimum of 1.

## Structure
- Shared package `mux_scan_pkg`:
  - `NUM_CH`=4 and `SEL_W`=2 constants.
  - State typedef (IDLE/SETTLE/DONE).
  - Function `next_ch(mask, cur)` returning the next enabled index above `cur`, plus a found flag.
- No sub-module. A single FSM+datapath module is natural; the priority search lives in the package function.

## Test plan
- `DWELL`=2, `en`=4'b1111, `d`=4'b1010 on the mux, `start` pulse:
  - `select` sequence 0,0,1,1,2,2,3,3.
  - `valid` on the 8th edge after acceptance.
  - `data`=4'b1010; `busy` high for 8 cycles.
- `en`=4'b0101, `d`=4'b1111, `DWELL`=1:
  - `select` 0 then 2.
  - `valid` on the 2nd edge.
  - `data`=4'b0101.
- `en`=0 with `start`: `valid` on the next edge, `data`=0, `busy` never 1.
- `start` held high continuously, `en`=4'b1000:
  - Scans run back-to-back via DONE→SETTLE.
  - `valid` every `DWELL`+1 cycles.
  - Pulses of `start` while `busy`=1 are ignored.
- Toggle `d[1]` mid-dwell with `DWELL`=3: the captured bit equals the value present on the sample edge, i.e. the 3rd edge.
- Assert `rst_n`=0 mid-scan: next edge gives IDLE, `select`=0, `busy`=0, `data`=0, and no `valid` strobe.
